matrix_result_streamer: RTL and testbench
=========================================

Name: matrix_result_streamer

Overview:
- Downstream stage of the systolic matrix multiplier.
- Detects the multiplier's done/ready level and captures the registered SIZE x SIZE product matrix into a local buffer.
- Serialises the buffer as a valid/ready element stream with row/column indices and a last-element flag.
- Frees the multiplier to start the next product while the previous one drains.

Parameters:
WIDTH, 16, bit width of each product element (matches multiplier output width)
SIZE, 3, matrix order N; N*N elements per frame
COL_MAJOR, 0, 0 = row-major emission order (row outer, col inner); 1 = column-major
IDXW, $clog2(SIZE) (min 1), width of index outputs

Ports:
clock  input  1  clock, rising edge
nreset  input  1  asynchronous active-low reset
done_i  input  1  multiplier ready level; rising edge marks a new result
prod_i  input  [SIZE-1:0][SIZE-1:0] x WIDTH  product matrix from multiplier registered output
m_valid  output  1  stream element valid
m_ready  input  1  downstream accept
m_data  output  WIDTH  element value
m_row  output  IDXW  row index of m_data
m_col  output  IDXW  column index of m_data
m_last  output  1  high with element (SIZE-1,SIZE-1)
busy_o  output  1  high in ARM or STREAM
overrun_o  output  1  sticky: a result was dropped
clear_i  input  1  synchronous clear of overrun_o
frame_cnt_o  output  16  completed frames, wraps at 2^16

Behaviour:
- Reset (async, nreset=0):
  - state IDLE; all outputs 0.
  - buffer contents don't-care; done_d register = 0.
- Edge detect: rise = done_i & ~done_d; done_d registered every cycle.
- States IDLE, ARM, STREAM:
  - IDLE: rise -> ARM.
  - ARM (exactly 1 cycle, covers the multiplier's one-cycle output register):
    - next edge latches prod_i into buffer.
    - row=col=0; m_valid<=1; -> STREAM.
  - STREAM: m_data/m_row/m_col/m_last are registered and driven from the buffer at the current indices.
- Latency: rise sampled at edge E0; buffer latched and m_valid=1 after E1; first element visible the cycle after E1.
- Handshake:
  - Transfer on any edge with m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_data, m_row, m_col and m_last are held stable.
  - m_valid is never withdrawn before transfer.
- Index advance:
  - COL_MAJOR=0: col increments; on col=SIZE-1, col->0 and row++.
  - COL_MAJOR=1: roles swapped.
- m_last = (row==SIZE-1 && col==SIZE-1).
- Transfer of the m_last element:
  - frame_cnt_o++.
  - If rise on the same edge -> ARM (back-to-back, no gap beyond ARM); otherwise -> IDLE with m_valid<=0.
- Rise while in STREAM, except on the edge of the last transfer: result dropped, overrun_o<=1, current frame continues untouched.
- ARM cannot see a rise, since done_i must fall first.
- clear_i=1 forces overrun_o<=0. If it coincides with a new overrun event, set wins.
- done_i held high across frames produces one capture only; a new capture needs a fall then a rise.
- Buffer is written only in ARM. prod_i changes in IDLE/STREAM do not affect the stream.
- Reset mid-STREAM: immediate IDLE, m_valid=0, partial frame discarded, frame_cnt_o=0.
- busy_o = (state != IDLE).

Test Plan:
- Basic: SIZE=3, prod_i = {{1,2,3},{4,5,6},{7,8,9}} (index [r][c]); pulse done_i; m_ready=1 -> first m_valid 2 cycles after rise sample, then 9 consecutive beats 1..9 with (row,col) = (0,0)..(2,2), m_last only on 9, frame_cnt_o=1, busy_o low afterwards.
- Backpressure: same matrix, m_ready toggled 1,0,0,1,... -> data/indices stable during stalls, exactly 9 transfers in order, no duplicates.
- Overrun: done_i pulses again during beat 4 with prod_i all 0xFFFF -> stream still emits 1..9, overrun_o=1 stays set; clear_i pulse -> 0.
- Back-to-back: second rise on the exact edge of the beat-9 transfer with new matrix 10..18 -> ARM, then 10..18 with no overrun, frame_cnt_o=2.
- COL_MAJOR=1: matrix 1..9 -> order 1,4,7,2,5,8,3,6,9, m_last on 9.
- Reset mid-stream: nreset low after beat 5 -> m_valid, busy_o, frame_cnt_o, overrun_o all 0 immediately; next rise streams the full frame from (0,0).

Source files
------------

// File: rtl/matrix_result_streamer.sv
// Captures the systolic multiplier's product matrix on a done rise and replays it as an indexed
// valid/ready element stream; first element 2 cycles after the rise, outputs held while m_ready is low.
module matrix_result_streamer #(
    parameter int WIDTH     = 16,
    parameter int SIZE      = 3,
    parameter int COL_MAJOR = 0,
    parameter int IDXW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                                 clock,
    input  logic                                 nreset,
    input  logic                                 done_i,
    input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] prod_i,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [WIDTH-1:0]                     m_data,
    output logic [IDXW-1:0]                      m_row,
    output logic [IDXW-1:0]                      m_col,
    output logic                                 m_last,
    output logic                                 busy_o,
    output logic                                 overrun_o,
    input  logic                                 clear_i,
    output logic [15:0]                          frame_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE - 1);

    state_t                               state_q, state_d;
    logic                                 done_q;
    logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mat_q;
    logic [IDXW-1:0]                      row_q, row_d, col_q, col_d;
    logic [IDXW-1:0]                      row_nx, col_nx;
    logic [WIDTH-1:0]                     data_q, data_d;
    logic                                 valid_q, valid_d;
    logic                                 last_q, last_d;
    logic                                 overrun_q, overrun_d;
    logic [15:0]                          frame_cnt_q, frame_cnt_d;
    logic                                 rise, xfer, last_xfer;

    assign rise      = done_i & ~done_q;
    assign xfer      = valid_q & m_ready;
    assign last_xfer = xfer & last_q;

    // Next element position; the inner index wraps into the outer one.
    always_comb begin
        row_nx = row_q;
        col_nx = col_q;
        if (COL_MAJOR != 0) begin
            if (row_q == LAST_IDX) begin
                row_nx = '0;
                col_nx = col_q + 1'b1;
            end else begin
                row_nx = row_q + 1'b1;
            end
        end else begin
            if (col_q == LAST_IDX) begin
                col_nx = '0;
                row_nx = row_q + 1'b1;
            end else begin
                col_nx = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;

        if (clear_i) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                // prod_i is registered one cycle after done rises, so it is sampled here.
                row_d   = '0;
                col_d   = '0;
                data_d  = prod_i[0][0];
                last_d  = (SIZE == 1);
                valid_d = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (xfer) begin
                    if (last_q) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        valid_d     = 1'b0;
                        last_d      = 1'b0;
                        state_d     = rise ? ARM : IDLE;
                    end else begin
                        row_d  = row_nx;
                        col_d  = col_nx;
                        data_d = mat_q[row_nx][col_nx];
                        last_d = (row_nx == LAST_IDX) && (col_nx == LAST_IDX);
                    end
                end
                // A new result arriving mid-frame cannot be held; flag it, set beats clear.
                if (rise && !last_xfer) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_i;
            row_q       <= row_d;
            col_q       <= col_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == ARM) begin
            mat_q <= prod_i;
        end
    end

    assign m_valid     = valid_q;
    assign m_data      = data_q;
    assign m_row       = row_q;
    assign m_col       = col_q;
    assign m_last      = last_q;
    assign busy_o      = (state_q != IDLE);
    assign overrun_o   = overrun_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: row- and column-major instances share stimulus and are
// checked each cycle against a queue-based frame model, plus directed literal expectations.
module tb_matrix_result_streamer;
    localparam int W  = 16;
    localparam int N  = 3;
    localparam int IW = 2;
    localparam int CM_ORD [9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};

    typedef struct packed {
        logic [W-1:0]  d;
        logic [IW-1:0] r;
        logic [IW-1:0] c;
        logic          l;
    } beat_t;

    logic clock = 1'b0;
    logic nreset, done_i, m_ready, clear_i;
    logic [N-1:0][N-1:0][W-1:0] prod_i;

    logic          m_valid, m_last, busy_o, overrun_o;
    logic [W-1:0]  m_data;
    logic [IW-1:0] m_row, m_col;
    logic [15:0]   frame_cnt_o;

    logic          cm_valid, cm_last, cm_busy, cm_ovr;
    logic [W-1:0]  cm_data;
    logic [IW-1:0] cm_row, cm_col;
    logic [15:0]   cm_cnt;

    int checks = 0;
    int errors = 0;

    beat_t exp_rm[$], exp_cm[$], log_rm[$], log_cm[$];
    bit          md_vld, md_act, md_arm, md_ovr, md_prev;
    logic [15:0] md_cnt;

    always #5 clock = ~clock;

    matrix_result_streamer #(.WIDTH(W), .SIZE(N), .COL_MAJOR(0)) u_dut (
        .clock(clock), .nreset(nreset), .done_i(done_i), .prod_i(prod_i),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
        .m_col(m_col), .m_last(m_last), .busy_o(busy_o), .overrun_o(overrun_o),
        .clear_i(clear_i), .frame_cnt_o(frame_cnt_o)
    );

    matrix_result_streamer #(.WIDTH(W), .SIZE(N), .COL_MAJOR(1)) u_dut_cm (
        .clock(clock), .nreset(nreset), .done_i(done_i), .prod_i(prod_i),
        .m_valid(cm_valid), .m_ready(m_ready), .m_data(cm_data), .m_row(cm_row),
        .m_col(cm_col), .m_last(cm_last), .busy_o(cm_busy), .overrun_o(cm_ovr),
        .clear_i(clear_i), .frame_cnt_o(cm_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a queue of beats filled from the matrix in emission order.
    always @(negedge clock) begin
        if (!nreset) begin
            chk("rst_valid", m_valid, 0);   chk("rst_busy", busy_o, 0);
            chk("rst_ovr", overrun_o, 0);   chk("rst_cnt", frame_cnt_o, 0);
            chk("rst_data", m_data, 0);     chk("rst_last", m_last, 0);
            chk("rst_cm_valid", cm_valid, 0); chk("rst_cm_cnt", cm_cnt, 0);
            exp_rm.delete(); exp_cm.delete();
            md_vld = 0; md_act = 0; md_arm = 0; md_ovr = 0; md_prev = 0; md_cnt = 0;
        end else begin
            bit rise, xfer, lastx;
            chk("valid", m_valid, md_vld);       chk("cm_valid", cm_valid, md_vld);
            chk("busy", busy_o, md_arm | md_act); chk("cm_busy", cm_busy, md_arm | md_act);
            chk("overrun", overrun_o, md_ovr);   chk("cm_overrun", cm_ovr, md_ovr);
            chk("frame_cnt", frame_cnt_o, md_cnt); chk("cm_frame_cnt", cm_cnt, md_cnt);
            if (md_vld && exp_rm.size() > 0) begin
                chk("data", m_data, exp_rm[0].d); chk("row", m_row, exp_rm[0].r);
                chk("col", m_col, exp_rm[0].c);   chk("last", m_last, exp_rm[0].l);
                chk("cm_data", cm_data, exp_cm[0].d); chk("cm_row", cm_row, exp_cm[0].r);
                chk("cm_col", cm_col, exp_cm[0].c);   chk("cm_last", cm_last, exp_cm[0].l);
            end
            if (m_valid && m_ready) log_rm.push_back('{m_data, m_row, m_col, m_last});
            if (cm_valid && m_ready) log_cm.push_back('{cm_data, cm_row, cm_col, cm_last});

            rise    = done_i && !md_prev;
            md_prev = done_i;
            xfer    = md_vld && m_ready;
            lastx   = xfer && (exp_rm.size() == 1);
            if (rise && md_act && !lastx) md_ovr = 1;
            else if (clear_i) md_ovr = 0;
            if (md_arm) begin
                for (int k = 0; k < N * N; k++) begin
                    exp_rm.push_back('{prod_i[k / N][k % N], IW'(k / N), IW'(k % N), k == N * N - 1});
                    exp_cm.push_back('{prod_i[k % N][k / N], IW'(k % N), IW'(k / N), k == N * N - 1});
                end
                md_vld = 1; md_act = 1; md_arm = 0;
            end else if (xfer) begin
                void'(exp_rm.pop_front());
                void'(exp_cm.pop_front());
                if (lastx) begin
                    md_cnt = md_cnt + 16'd1;
                    md_vld = 0; md_act = 0;
                    if (rise) md_arm = 1;
                end
            end else if (!md_act && rise) begin
                md_arm = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_mat(input int base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                prod_i[r][c] = W'(base + r * N + c);
    endtask

    task automatic pulse();
        done_i = 1;
        tick();
        done_i = 0;
    endtask

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while ((log_rm.size() < n || m_valid) && k < 200) begin
            tick();
            k++;
        end
        chk(name, (k < 200), 1);
    endtask

    task automatic wait_beat(input int v, input string name);
        int k = 0;
        while (!(m_valid && m_data == W'(v)) && k < 200) begin
            tick();
            k++;
        end
        chk(name, (k < 200), 1);
    endtask

    task automatic chk_frame(input int first, input int base, input string name);
        for (int k = 0; k < N * N; k++) begin
            chk({name, "_d"}, log_rm[first + k].d, base + k);
            chk({name, "_r"}, log_rm[first + k].r, k / N);
            chk({name, "_c"}, log_rm[first + k].c, k % N);
            chk({name, "_l"}, log_rm[first + k].l, k == N * N - 1);
            chk({name, "_cm"}, log_cm[first + k].d, base + CM_ORD[k]);
        end
    endtask

    initial begin
        nreset = 0; done_i = 0; m_ready = 1; clear_i = 0;
        set_mat(1);
        tick(); tick();
        nreset = 1;
        tick();

        // Basic frame with literal latency and order.
        log_rm.delete(); log_cm.delete();
        done_i = 1; tick();
        chk("arm_valid", m_valid, 0); chk("arm_busy", busy_o, 1);
        done_i = 0; tick();
        chk("first_valid", m_valid, 1); chk("first_data", m_data, 1);
        for (int i = 0; i < N * N; i++) tick();
        chk("basic_beats", log_rm.size(), 9);
        chk("basic_idle_valid", m_valid, 0);
        chk("basic_busy", busy_o, 0);
        chk("basic_cnt", frame_cnt_o, 1);
        chk_frame(0, 1, "basic");

        // Backpressure with ready pattern 1,0,0,1.
        log_rm.delete(); log_cm.delete();
        pulse();
        begin
            int k = 0;
            while ((log_rm.size() < 9 || m_valid) && k < 100) begin
                m_ready = (k % 4 == 0) || (k % 4 == 3);
                tick();
                k++;
            end
            chk("bp_timeout", (k < 100), 1);
        end
        m_ready = 1;
        tick(); tick();
        chk("bp_beats", log_rm.size(), 9);
        chk_frame(0, 1, "bp");
        chk("bp_cnt", frame_cnt_o, 2);

        // Overrun during beat 4.
        log_rm.delete(); log_cm.delete();
        set_mat(1);
        pulse();
        wait_beat(4, "ovr_wait4");
        set_mat(0); for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) prod_i[r][c] = 16'hFFFF;
        done_i = 1; tick(); done_i = 0;
        wait_log(9, "ovr_wait_end");
        chk_frame(0, 1, "ovr");
        chk("ovr_set", overrun_o, 1);
        chk("ovr_cnt", frame_cnt_o, 3);
        clear_i = 1; tick(); clear_i = 0;
        chk("ovr_clear", overrun_o, 0);

        // Back-to-back: rise on the edge of the last transfer.
        log_rm.delete(); log_cm.delete();
        set_mat(1);
        pulse();
        wait_beat(9, "b2b_wait9");
        chk("b2b_last", m_last, 1);
        set_mat(10);
        done_i = 1; tick();
        chk("b2b_arm_valid", m_valid, 0); chk("b2b_arm_busy", busy_o, 1);
        done_i = 0; tick();
        chk("b2b_valid", m_valid, 1); chk("b2b_data", m_data, 10);
        wait_log(18, "b2b_wait_end");
        chk_frame(0, 1, "b2b1");
        chk_frame(9, 10, "b2b2");
        chk("b2b_ovr", overrun_o, 0);
        chk("b2b_cnt", frame_cnt_o, 5);

        // Reset after beat 5 with overrun pending.
        log_rm.delete(); log_cm.delete();
        set_mat(1);
        pulse();
        wait_beat(2, "rst_wait2");
        done_i = 1; tick(); done_i = 0;
        begin
            int k = 0;
            while (log_rm.size() < 5 && k < 100) begin tick(); k++; end
            chk("rst_wait5", (k < 100), 1);
        end
        chk("pre_rst_ovr", overrun_o, 1);
        nreset = 0;
        #1;
        chk("mid_rst_valid", m_valid, 0); chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_cnt", frame_cnt_o, 0); chk("mid_rst_ovr", overrun_o, 0);
        tick();
        nreset = 1;
        log_rm.delete(); log_cm.delete();
        pulse();
        wait_log(9, "rst_refill");
        chk_frame(0, 1, "after_rst");
        chk("after_rst_cnt", frame_cnt_o, 1);

        // Randomized traffic checked by the model.
        log_rm.delete(); log_cm.delete();
        for (int i = 0; i < 3000; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            clear_i = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 4) == 0) done_i = ~done_i;
            if ($urandom_range(0, 3) == 0)
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        prod_i[r][c] = W'($urandom);
            nreset = ($urandom_range(0, 399) != 0);
            tick();
            if (log_rm.size() > 1000) begin log_rm.delete(); log_cm.delete(); end
        end
        nreset = 1; done_i = 0; clear_i = 0; m_ready = 1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
